// File: rtl/ysyx_22050710_ifq.sv
// ---------------------------------------------------------------------------
// ysyx_22050710_ifq -- instruction fetch queue between fetch and decode.
//
// Buffers up to DEPTH {pc, inst} pairs in a circular buffer. Fetch and decode
// each talk to the queue through a valid/ready handshake. A flush drops
// every buffered entry at the clock edge.
//
// Parameters:
//   DEPTH  - number of entries (power of two, >= 2)
//   PC_W   - pc width
//   INST_W - instruction width
//
// Ports:
//   i_clk        clock, all state updates on the rising edge
//   i_rst        synchronous active-low reset; overrides flush and handshakes
//   i_flush      synchronous flush; empties the queue at this edge
//   i_in_valid   fetch presents {i_in_pc, i_in_inst}
//   o_in_ready   queue accepts a pair this cycle
//   o_out_valid  head entry available to decode
//   i_out_ready  decode consumes the head this cycle
//   o_out_pc     head pc   (0 when empty and nothing is forwarded)
//   o_out_inst   head inst (0 when empty and nothing is forwarded)
//   o_count      occupied entries, 0..DEPTH
//   o_empty      o_count == 0
//   o_full       o_count == DEPTH
//
// Build option:
//   YSYX_22050710_IFQ_BYPASS_EN - when defined, an empty queue forwards the
//   incoming pair straight to decode in the same cycle. If decode takes it,
//   the pair is never written. When undefined there is no forwarding path and
//   the minimum latency through the queue is one cycle.
// ---------------------------------------------------------------------------
module ysyx_22050710_ifq #(
  parameter int DEPTH  = 4,
  parameter int PC_W   = 64,
  parameter int INST_W = 32
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_flush,
  input  logic                   i_in_valid,
  output logic                   o_in_ready,
  input  logic [PC_W-1:0]        i_in_pc,
  input  logic [INST_W-1:0]      i_in_inst,
  output logic                   o_out_valid,
  input  logic                   i_out_ready,
  output logic [PC_W-1:0]        o_out_pc,
  output logic [INST_W-1:0]      o_out_inst,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_empty,
  output logic                   o_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [PC_W-1:0]   pc_mem_q   [DEPTH];
  logic [INST_W-1:0] inst_mem_q [DEPTH];

  logic push;        // fetch handshake completes
  logic pop;         // decode handshake completes
  logic bypass_hit;  // pop served by the forwarding path, storage untouched
  logic wr_en;       // pair is actually written into storage
  logic rd_adv;      // head entry actually leaves storage

  assign o_count = count_q;
  assign o_empty = (count_q == '0);
  assign o_full  = (count_q == FULL_CNT);

  // A full queue never accepts, even if decode frees a slot this cycle; that
  // keeps o_in_ready off the decode-side combinational path.
  assign o_in_ready = ~o_full & ~i_flush;

`ifdef YSYX_22050710_IFQ_BYPASS_EN
  logic fwd;
  assign fwd         = o_empty & ~i_flush;
  assign o_out_valid = fwd ? i_in_valid : (~o_empty & ~i_flush);
  assign bypass_hit  = fwd & pop;
`else
  assign o_out_valid = ~o_empty & ~i_flush;
  assign bypass_hit  = 1'b0;
`endif

  assign push   = i_in_valid & o_in_ready;
  assign pop    = o_out_valid & i_out_ready;
  assign wr_en  = push & ~bypass_hit;
  assign rd_adv = pop & ~bypass_hit;

  // Head data: stored entry when occupied, otherwise forwarded input (bypass
  // build only) or zero.
  always_comb begin
    o_out_pc   = '0;
    o_out_inst = '0;
    if (!o_empty) begin
      o_out_pc   = pc_mem_q[rd_ptr_q];
      o_out_inst = inst_mem_q[rd_ptr_q];
    end
`ifdef YSYX_22050710_IFQ_BYPASS_EN
    else if (!i_flush) begin
      o_out_pc   = i_in_pc;
      o_out_inst = i_in_inst;
    end
`endif
  end

  // NOTE: every signal gets its hold value before any branch, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    // DEPTH is a power of two, so the natural AW-bit overflow is the wrap.
    if (wr_en)  wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_adv) rd_ptr_d = rd_ptr_q + AW'(1);

    unique case ({wr_en, rd_adv})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Handshakes are already masked by i_flush; the flush only has to
    // collapse the pointers and the count.
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of the others, independent of block order.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; count_q gates every read, so
  // stale contents are never observable and the array stays plain RAM.
  always_ff @(posedge i_clk) begin
    if (i_rst && wr_en) begin
      pc_mem_q[wr_ptr_q]   <= i_in_pc;
      inst_mem_q[wr_ptr_q] <= i_in_inst;
    end
  end

endmodule

// File: tb/tb_ysyx_22050710_ifq.sv
// ---------------------------------------------------------------------------
// Self-checking bench for ysyx_22050710_ifq.
//
// The driver applies one cycle of stimulus at a time and predicts the
// outcome with a reference queue of {pc, inst}. Status expectations go into
// exp_* variables; every pair the model says decode will consume is pushed
// into a scoreboard queue. An independent monitor samples the DUT on the
// falling edge, checks status, and pops/compares the scoreboard whenever the
// DUT completes a decode-side handshake.
// ---------------------------------------------------------------------------
module tb_ysyx_22050710_ifq;

  localparam int DEPTH  = 4;
  localparam int PC_W   = 64;
  localparam int INST_W = 32;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  logic                   i_clk;
  logic                   i_rst;
  logic                   i_flush;
  logic                   i_in_valid;
  logic                   o_in_ready;
  logic [PC_W-1:0]        i_in_pc;
  logic [INST_W-1:0]      i_in_inst;
  logic                   o_out_valid;
  logic                   i_out_ready;
  logic [PC_W-1:0]        o_out_pc;
  logic [INST_W-1:0]      o_out_inst;
  logic [$clog2(DEPTH):0] o_count;
  logic                   o_empty;
  logic                   o_full;

  ysyx_22050710_ifq #(
    .DEPTH (DEPTH),
    .PC_W  (PC_W),
    .INST_W(INST_W)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_flush    (i_flush),
    .i_in_valid (i_in_valid),
    .o_in_ready (o_in_ready),
    .i_in_pc    (i_in_pc),
    .i_in_inst  (i_in_inst),
    .o_out_valid(o_out_valid),
    .i_out_ready(i_out_ready),
    .o_out_pc   (o_out_pc),
    .o_out_inst (o_out_inst),
    .o_count    (o_count),
    .o_empty    (o_empty),
    .o_full     (o_full)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model and scoreboard.
  entry_t ref_q[$];
  entry_t exp_q[$];

  // Per-cycle expectations written by the driver, read by the monitor.
  bit     chk_en = 1'b0;
  int     exp_count;
  bit     exp_empty, exp_full, exp_in_ready, exp_out_valid;
  entry_t exp_head;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // One cycle of normal operation: drive inputs, predict, advance the clock.
  task automatic step(input logic v, input logic [PC_W-1:0] pc, input logic [INST_W-1:0] inst,
                      input logic rdy, input logic fl);
    int     n;
    bit     fwd, push, pop;
    entry_t in_e;
    in_e        = '{pc: pc, inst: inst};
    i_rst       = 1'b1;
    i_in_valid  = v;
    i_in_pc     = pc;
    i_in_inst   = inst;
    i_out_ready = rdy;
    i_flush     = fl;

    n = ref_q.size();
`ifdef YSYX_22050710_IFQ_BYPASS_EN
    fwd = (n == 0) && !fl;
`else
    fwd = 1'b0;
`endif
    exp_count     = n;
    exp_empty     = (n == 0);
    exp_full      = (n == DEPTH);
    exp_in_ready  = (n < DEPTH) && !fl;
    exp_out_valid = fwd ? v : ((n > 0) && !fl);
    if (n > 0)    exp_head = ref_q[0];
    else if (fwd) exp_head = in_e;
    else          exp_head = '0;

    push = v && exp_in_ready;
    pop  = exp_out_valid && rdy;
    if (pop) begin
      if (fwd) exp_q.push_back(in_e);
      else     exp_q.push_back(ref_q.pop_front());
    end
    if (push && !(pop && fwd)) ref_q.push_back(in_e);
    if (fl) ref_q.delete();

    chk_en = 1'b1;
    @(posedge i_clk);
    #1;
  endtask

  // Reset with fetch still offering a pair: nothing may be enqueued.
  task automatic reset_cycles(input int cycles);
    chk_en      = 1'b0;
    i_rst       = 1'b0;
    i_flush     = 1'b0;
    i_in_valid  = 1'b1;
    i_in_pc     = 64'hdead_beef_0000_0000;
    i_in_inst   = 32'hdead_beef;
    i_out_ready = 1'b0;
    repeat (cycles) @(posedge i_clk);
    #1;
    ref_q.delete();
  endtask

  // Monitor: status every cycle, scoreboard on each decode handshake.
  entry_t mon_e;
  always @(negedge i_clk) begin
    if (chk_en) begin
      check("count",     64'(o_count),     64'(exp_count));
      check("empty",     64'(o_empty),     64'(exp_empty));
      check("full",      64'(o_full),      64'(exp_full));
      check("in_ready",  64'(o_in_ready),  64'(exp_in_ready));
      check("out_valid", 64'(o_out_valid), 64'(exp_out_valid));
      check("head_pc",   o_out_pc,         exp_head.pc);
      check("head_inst", 64'(o_out_inst),  64'(exp_head.inst));
      if (o_out_valid && i_out_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL pop_unexpected: got pc 0x%0h, expected no pop (t=%0t)", o_out_pc, $time);
        end else begin
          mon_e = exp_q.pop_front();
          check("pop_pc",   o_out_pc,        mon_e.pc);
          check("pop_inst", 64'(o_out_inst), 64'(mon_e.inst));
        end
      end
    end
  end

  localparam logic [INST_W-1:0] NOP = 32'h0000_0013;

  initial begin
    i_rst = 1'b0; i_flush = 1'b0; i_in_valid = 1'b0; i_in_pc = '0;
    i_in_inst = '0; i_out_ready = 1'b0;

    // Reset held two cycles while fetch offers a pair.
    reset_cycles(2);
    step(1'b0, '0, '0, 1'b1, 1'b0);

    // Fill to full, try a rejected push, then full with simultaneous pop.
    for (int i = 0; i < DEPTH; i++)
      step(1'b1, 64'h8000_0000 + 64'(4 * i), NOP, 1'b0, 1'b0);
    step(1'b1, 64'h8000_0010, NOP, 1'b0, 1'b0);
    step(1'b1, 64'h8000_0010, NOP, 1'b1, 1'b0);
    step(1'b1, 64'h8000_0010, NOP, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b0);
    repeat (DEPTH + 1) step(1'b0, '0, '0, 1'b1, 1'b0);

    // Wrap-around: count held at 2 through 10 push&pop cycles.
    for (int i = 0; i < 2; i++)
      step(1'b1, 64'h8000_2000 + 64'(4 * i), NOP, 1'b0, 1'b0);
    for (int i = 2; i < 12; i++)
      step(1'b1, 64'h8000_2000 + 64'(4 * i), NOP + INST_W'(i), 1'b1, 1'b0);
    repeat (3) step(1'b0, '0, '0, 1'b1, 1'b0);

    // Flush mid-stream with both handshakes offered.
    for (int i = 0; i < 3; i++)
      step(1'b1, 64'h8000_3000 + 64'(4 * i), NOP, 1'b0, 1'b0);
    step(1'b1, 64'h8000_3100, NOP, 1'b1, 1'b1);
    step(1'b1, 64'h8000_1000, NOP, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);

    // Empty queue with a pair and decode ready: same cycle or one later.
    step(1'b1, 64'h8000_0010, NOP, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);

    // Reset mid-stream.
    for (int i = 0; i < 3; i++)
      step(1'b1, 64'h8000_4000 + 64'(4 * i), NOP, 1'b0, 1'b0);
    reset_cycles(1);
    step(1'b0, '0, '0, 1'b1, 1'b0);

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        reset_cycles(1);
      end else begin
        step($urandom_range(0, 3) != 0, {$urandom, $urandom}, $urandom,
             $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);
      end
    end

    repeat (DEPTH + 2) step(1'b0, '0, '0, 1'b1, 1'b0);
    chk_en = 1'b0;
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
